// File: rtl/denge_sirali_denetleyici.sv
// denge_sirali_denetleyici: walks three balance rods through one shared rod evaluator
// and reports the majority fall direction, the right-fall count and an invalid-rod flag.
module denge_sirali_denetleyici #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_A,
  input  logic [2:0]       in_B,
  output logic             cubuk_A,
  output logic             cubuk_B,
  input  logic [1:0]       cubuk_D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_D,
  output logic [1:0]       out_sag_sayisi,
  output logic             out_hata,
  input  logic             sayac_temizle,
  output logic [CNT_W-1:0] islem_sayisi,
  output logic [CNT_W-1:0] hata_sayisi
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_a, r_b, r_sag;
  logic             r_hata;
  logic [1:0]       r_idx;
  logic             r_out_d, r_out_hata;
  logic [1:0]       r_out_sag;
  logic [CNT_W-1:0] r_islem, r_hata_say;
  logic             w_accept, w_handshake, w_last, w_rod_err, w_hata_next;
  logic [2:0]       w_sag_next;
  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cubuk_A     = 1'b0;
    cubuk_B     = 1'b0;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    w_last      = r_idx == 2'd2;
    if (r_state == IDLE) begin
      in_ready = 1'b1;
      w_accept = in_valid;
      w_next   = in_valid ? EVAL : IDLE;
    end else if (r_state == EVAL) begin
      cubuk_A = r_a[r_idx];
      cubuk_B = r_b[r_idx];
      w_next  = w_last ? DONE : EVAL;
    end else begin
      out_valid   = 1'b1;
      w_handshake = out_ready;
      w_next      = out_ready ? IDLE : DONE;
    end
  end
  // 00 and 11 are both invalid; D[1] is still taken as the rod's vote
  assign w_rod_err   = cubuk_D[1] ~^ cubuk_D[0];
  assign w_hata_next = r_hata | w_rod_err;
  assign w_sag_next  = {r_idx == 2'd2 ? cubuk_D[1] : r_sag[2],
                        r_idx == 2'd1 ? cubuk_D[1] : r_sag[1],
                        r_idx == 2'd0 ? cubuk_D[1] : r_sag[0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sag      <= '0;
      r_hata     <= 1'b0;
      r_idx      <= '0;
      r_out_d    <= 1'b0;
      r_out_sag  <= '0;
      r_out_hata <= 1'b0;
      r_islem    <= '0;
      r_hata_say <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= in_A;
        r_b    <= in_B;
        r_sag  <= '0;
        r_hata <= 1'b0;
        r_idx  <= '0;
      end else if (r_state == EVAL) begin
        r_sag  <= w_sag_next;
        r_hata <= w_hata_next;
        r_idx  <= w_last ? r_idx : r_idx + 2'd1;
      end
      // result registers load once on the last rod so they hold outside DONE
      if (r_state == EVAL && w_last) begin
        r_out_d    <= (w_sag_next[0] & w_sag_next[1]) | (w_sag_next[1] & w_sag_next[2]) |
                      (w_sag_next[0] & w_sag_next[2]);
        r_out_sag  <= 2'(w_sag_next[0]) + 2'(w_sag_next[1]) + 2'(w_sag_next[2]);
        r_out_hata <= w_hata_next;
      end
      if (sayac_temizle) begin
        r_islem    <= '0;
        r_hata_say <= '0;
      end else if (w_handshake) begin
        r_islem    <= (&r_islem) ? r_islem : r_islem + CNT_W'(1);
        r_hata_say <= (r_out_hata && !(&r_hata_say)) ? r_hata_say + CNT_W'(1) : r_hata_say;
      end
    end
  end
  assign out_D          = r_out_d;
  assign out_sag_sayisi = r_out_sag;
  assign out_hata       = r_out_hata;
  assign islem_sayisi   = r_islem;
  assign hata_sayisi    = r_hata_say;
endmodule
